// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, feeder FSM encoding and default feeder sizing.
package uart_pkg;

  localparam int unsigned UART_DATA_W      = 8;
  localparam int unsigned FEED_DEPTH_DEF   = 8;
  localparam int unsigned FEED_GAP_DEF     = 0;
  localparam int unsigned FEED_TIMEOUT_DEF = 4;

  // Counter widths sized for the legal ranges of GAP_CYCLES (0..255) and BUSY_TIMEOUT (2..15)
  localparam int unsigned FEED_GAP_W = 8;
  localparam int unsigned FEED_TO_W  = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    FEED_IDLE      = 3'd0,
    FEED_LAUNCH    = 3'd1,
    FEED_WAIT_BUSY = 3'd2,
    FEED_WAIT_DONE = 3'd3,
    FEED_GAP       = 3'd4
  } feed_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO for the UART feeder: storage, wrap-around pointers, occupancy count.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = FEED_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  uart_byte_t             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   rd_pop,
  output uart_byte_t             rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  uart_byte_t        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_c;
  logic              pop_c;

  // Full gates the write outright, so a pop in the same cycle never lets a full write through
  assign wr_ready = (count != CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign rd_data  = mem[rd_ptr];
  assign push_c   = wr_valid & wr_ready;
  assign pop_c    = rd_pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered bytes to a UART transmitter one frame at a time with launch retry and idle gap.
// Optional UART_TX_FEEDER_CTS_EN adds a synchronized active-low cts_n launch gate.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = FEED_DEPTH_DEF,
  parameter int unsigned GAP_CYCLES   = FEED_GAP_DEF,
  parameter int unsigned BUSY_TIMEOUT = FEED_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   launch_err,
  input  logic                   err_clr
`ifdef UART_TX_FEEDER_CTS_EN
  ,
  input  logic                   cts_n
`endif
);

  feed_state_e           state;
  feed_state_e           state_nx;
  uart_byte_t            fifo_rd_data;
  logic                  pop_c;
  logic                  cts_ok_c;
  logic                  err_set_c;
  logic                  tx_start_nx;
  uart_byte_t            tx_data_nx;
  logic                  launch_err_nx;
  logic [FEED_GAP_W-1:0] gap_cnt;
  logic [FEED_GAP_W-1:0] gap_cnt_nx;
  logic [FEED_TO_W-1:0]  to_cnt;
  logic [FEED_TO_W-1:0]  to_cnt_nx;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_pop   (pop_c),
    .rd_data  (fifo_rd_data),
    .level    (level),
    .empty    (empty)
  );

`ifdef UART_TX_FEEDER_CTS_EN
  logic [1:0] cts_sync;

  // Two-flop synchronizer; resets to "not clear" so nothing launches before cts_n is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], cts_n};
    end
  end

  assign cts_ok_c = ~cts_sync[1];
`else
  assign cts_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FEED_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      launch_err <= 1'b0;
      gap_cnt    <= FEED_GAP_W'(GAP_CYCLES);
      to_cnt     <= '0;
    end else begin
      state      <= state_nx;
      tx_start   <= tx_start_nx;
      tx_data    <= tx_data_nx;
      launch_err <= launch_err_nx;
      gap_cnt    <= gap_cnt_nx;
      to_cnt     <= to_cnt_nx;
    end
  end

  // Next-state and output decode; tx_data only moves on a pop, so retries resend the same byte
  always_comb begin
    state_nx    = state;
    tx_start_nx = 1'b0;
    tx_data_nx  = tx_data;
    gap_cnt_nx  = gap_cnt;
    to_cnt_nx   = to_cnt;
    pop_c       = 1'b0;
    err_set_c   = 1'b0;

    case (state)
      FEED_IDLE: begin
        if (!empty && cts_ok_c) begin
          pop_c       = 1'b1;
          tx_data_nx  = fifo_rd_data;
          tx_start_nx = 1'b1;
          state_nx    = FEED_LAUNCH;
        end
      end
      FEED_LAUNCH: begin
        to_cnt_nx = '0;
        state_nx  = FEED_WAIT_BUSY;
      end
      FEED_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = FEED_WAIT_DONE;
        end else begin
          to_cnt_nx = to_cnt + FEED_TO_W'(1);
          if (to_cnt == FEED_TO_W'(BUSY_TIMEOUT - 1)) begin
            err_set_c   = 1'b1;
            tx_start_nx = 1'b1;
            state_nx    = FEED_LAUNCH;
          end
        end
      end
      FEED_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_cnt_nx = FEED_GAP_W'(GAP_CYCLES);
          state_nx   = FEED_GAP;
        end
      end
      FEED_GAP: begin
        if (gap_cnt == '0) begin
          state_nx = FEED_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - FEED_GAP_W'(1);
        end
      end
      default: begin
        state_nx = FEED_IDLE;
      end
    endcase

    launch_err_nx = err_set_c ? 1'b1 : (err_clr ? 1'b0 : launch_err);
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed-plus-random bench for uart_tx_feeder with a behavioural transmitter and frame scoreboard.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 5;
  localparam int unsigned TMO   = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [LW-1:0] level;
  logic          empty;
  logic          launch_err;
  logic          err_clr;
`ifdef UART_TX_FEEDER_CTS_EN
  logic          cts_n = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Transmitter model state
  bit  respond  = 1'b1;
  bit  rand_len = 1'b0;
  int  busy_len = 160;
  int  busy_left;
  int  start_cnt = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .level      (level),
    .empty      (empty),
    .launch_err (launch_err),
    .err_clr    (err_clr)
`ifdef UART_TX_FEEDER_CTS_EN
    ,
    .cts_n      (cts_n)
`endif
  );

  always #5 clk = ~clk;

  // Transmitter: goes busy at the edge that samples tx_start, stays busy for a frame length, records the byte
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else begin
      if (tx_start) start_cnt <= start_cnt + 1;
      if (tx_busy) begin
        if (busy_left <= 1) tx_busy <= 1'b0;
        else busy_left <= busy_left - 1;
      end else if (tx_start && respond) begin
        tx_busy   <= 1'b1;
        busy_left <= rand_len ? int'($urandom_range(12, 2)) : busy_len;
        sent_q.push_back(tx_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int n = 0;
    while (tx_busy !== val && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 32'(tx_busy), 32'(val));
  endtask

  task automatic wait_level(input int unsigned val, input string tag);
    int n = 0;
    while (level !== LW'(val) && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 32'(level), 32'(val));
  endtask

  // Wait for every expected frame to be sent, then compare the frame order against the scoreboard
  task automatic drain(input string tag);
    int n = 0;
    while ((sent_q.size() != exp_q.size() || tx_busy !== 1'b0 || level !== '0) && n < 5000) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk({tag, "_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_byte"}, (i < sent_q.size()) ? 32'(sent_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    end
    sent_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int s0;
    int mlvl;
    logic [7:0] b;

    wr_valid = 1'b0;
    wr_data  = '0;
    err_clr  = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_launch_err", 32'(launch_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte: launch the cycle after the edge following the write
    s0 = start_cnt;
    wr(8'hA5);
    exp_q.push_back(8'hA5);
    chk("single_e0_start", 32'(tx_start), 32'd0);
    chk("single_e0_level", 32'(level), 32'd1);
    tick();
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_level", 32'(level), 32'd0);
    chk("single_empty", 32'(empty), 32'd1);
    tick();
    chk("single_start_low", 32'(tx_start), 32'd0);
    tick();

    // Burst of 9 while the 0xA5 frame is on the line: only 8 fit
    mlvl = 0;
    for (int i = 1; i <= 9; i++) begin
      wr_data  = 8'(i);
      wr_valid = 1'b1;
      tick();
      if (mlvl < int'(DEPTH)) begin
        exp_q.push_back(8'(i));
        mlvl++;
      end
      if (i == 8) begin
        chk("burst_ready_full", 32'(wr_ready), 32'd0);
        chk("burst_level_full", 32'(level), 32'(DEPTH));
      end
    end
    wr_valid = 1'b0;
    chk("burst_level_drop", 32'(level), 32'(DEPTH));
    chk("burst_data_hold", 32'(tx_data), 32'hA5);

    // Gap and simultaneous push/pop: busy falls at edge F, feeder samples it at F+1,
    // next launch must land exactly GAP+2 edges after that, i.e. at F+8 here
    busy_len = 30;
    wait_level(3, "pp_level3");
    wait_busy(1'b1, "pp_busy_hi");
    wait_busy(1'b0, "pp_busy_lo");
    for (int k = 1; k <= int'(GAP) + 2; k++) begin
      tick();
      chk("gap_hold", 32'(tx_start), 32'd0);
    end
    wr_data  = 8'hC3;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    exp_q.push_back(8'hC3);
    chk("gap_start", 32'(tx_start), 32'd1);
    chk("pp_level", 32'(level), 32'd3);
    chk("pp_data", 32'(tx_data), 32'h06);
    drain("order1");
    chk("order1_starts", 32'(start_cnt - s0), 32'd10);

    // Random bytes and frame lengths, enough traffic to wrap the pointers several times
    rand_len = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < 24; i++) begin
      int n = 0;
      while ((exp_q.size() - sent_q.size()) >= 4 && n < 3000) begin
        tick();
        n++;
      end
      b = 8'($urandom);
      chk("rand_ready", 32'(wr_ready), 32'd1);
      wr(b);
      exp_q.push_back(b);
      repeat ($urandom_range(3, 0)) tick();
    end
    drain("rand");
    chk("rand_starts", 32'(start_cnt - s0), 32'd24);

    // Busy timeout: retry every TMO+1 cycles with the same byte, set beats clear
    respond = 1'b0;
    s0 = start_cnt;
    wr(8'h5A);
    exp_q.push_back(8'h5A);
    tick();
    chk("to_first_start", 32'(tx_start), 32'd1);
    repeat (TMO) tick();
    chk("to_err_early", 32'(launch_err), 32'd0);
    tick();
    chk("to_err_set", 32'(launch_err), 32'd1);
    chk("to_retry_start", 32'(tx_start), 32'd1);
    chk("to_retry_data", 32'(tx_data), 32'h5A);
    repeat (TMO) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_set_wins", 32'(launch_err), 32'd1);
    chk("to_retry2_start", 32'(tx_start), 32'd1);
    respond = 1'b1;
    repeat (2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_cleared", 32'(launch_err), 32'd0);
    repeat (20) tick();
    chk("to_err_stays", 32'(launch_err), 32'd0);
    drain("timeout");
    chk("to_starts", 32'(start_cnt - s0), 32'd3);

    // Reset in mid-frame with bytes still queued
    rand_len = 1'b0;
    busy_len = 100;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    wr(8'h44);
    chk("rst_mid_level", 32'(level), 32'd3);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_start", 32'(tx_start), 32'd0);
    chk("rst_mid_level0", 32'(level), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sent_q.delete();
    exp_q.delete();
    s0 = start_cnt;
    repeat (20) tick();
    chk("rst_no_launch", 32'(start_cnt - s0), 32'd0);
    wr(8'h3C);
    exp_q.push_back(8'h3C);
    tick();
    chk("rst_new_start", 32'(tx_start), 32'd1);
    chk("rst_new_data", 32'(tx_data), 32'h3C);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
